// File: rtl/be_pkg.sv
// Shared types and op-classification helpers for the back-end multiply/divide unit.
package be_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } RV32I_MDU_OP_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_div(input RV32I_MDU_OP_t op);
        case (op)
            MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU: is_div = 1'b1;
            default:                              is_div = 1'b0;
        endcase
    endfunction

    function automatic logic is_rem(input RV32I_MDU_OP_t op);
        case (op)
            MDU_REM, MDU_REMU: is_rem = 1'b1;
            default:           is_rem = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_a(input RV32I_MDU_OP_t op);
        case (op)
            MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: is_signed_a = 1'b1;
            default:                                is_signed_a = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_b(input RV32I_MDU_OP_t op);
        case (op)
            MDU_MULH, MDU_DIV, MDU_REM: is_signed_b = 1'b1;
            default:                    is_signed_b = 1'b0;
        endcase
    endfunction

    function automatic logic returns_high(input RV32I_MDU_OP_t op);
        case (op)
            MDU_MULH, MDU_MULHSU, MDU_MULHU: returns_high = 1'b1;
            default:                         returns_high = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring trial-subtract divide.
// The divide half exists only when RV32I_MDU_DIV_EN is defined.
module rv32i_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            div_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opb_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   sum_s;
`ifdef RV32I_MDU_DIV_EN
    logic [XLEN:0]   shift_s;
    logic [XLEN-1:0] diff_s;
    logic            ge_s;
`endif

    // Single iteration: {acc,lo} is the product register or the {remainder,quotient} pair
    always_comb begin
        sum_s = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opb_i} : {(XLEN+1){1'b0}});
`ifdef RV32I_MDU_DIV_EN
        shift_s = {acc_i, lo_i[XLEN-1]};
        // A set top bit of the shifted remainder always exceeds the divisor; the wrapped difference is exact
        diff_s  = shift_s[XLEN-1:0] - opb_i;
        ge_s    = shift_s[XLEN] | (shift_s[XLEN-1:0] >= opb_i);
        if (div_i) begin
            acc_o = ge_s ? diff_s : shift_s[XLEN-1:0];
            lo_o  = {lo_i[XLEN-2:0], ge_s};
        end else begin
            acc_o = sum_s[XLEN:1];
            lo_o  = {sum_s[0], lo_i[XLEN-1:1]};
        end
`else
        if (div_i) begin
            acc_o = {XLEN{1'b0}};
            lo_o  = {XLEN{1'b0}};
        end else begin
            acc_o = sum_s[XLEN:1];
            lo_o  = {sum_s[0], lo_i[XLEN-1:1]};
        end
`endif
    end

endmodule

// File: rtl/rv32i_muldiv.sv
// Iterative RV32M multiply/divide unit with start/ready handshake and one-cycle valid pulse.
// Define RV32I_MDU_DIV_EN to build the divider; otherwise divide ops return 0 with illegal_o.
module rv32i_muldiv
    import be_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);

    localparam int              CW   = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    RV32I_MDU_OP_t   op_s, op_q;
    mdu_state_t      state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_q, lo_q, opb_q, pre_q, result_q;
    logic            neg_q, rneg_q, fast_q, ill_q, valid_q, illegal_q, ready_q;

    logic            a_neg_s, b_neg_s, fast_s, fast_ill_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s, fast_res_s, fin_s;
    logic [XLEN-1:0] acc_d, lo_d;
    logic [2*XLEN-1:0] prod_s;

    assign op_s = RV32I_MDU_OP_t'(op_i);

    // Operand conditioning and fast-path detection at acceptance
    always_comb begin
        a_neg_s    = is_signed_a(op_s) & a_i[XLEN-1];
        b_neg_s    = is_signed_b(op_s) & b_i[XLEN-1];
        a_mag_s    = a_neg_s ? (ZERO - a_i) : a_i;
        b_mag_s    = b_neg_s ? (ZERO - b_i) : b_i;
        fast_s     = 1'b0;
        fast_ill_s = 1'b0;
        fast_res_s = ZERO;
`ifdef RV32I_MDU_DIV_EN
        if (is_div(op_s) && (b_i == ZERO)) begin
            fast_s     = 1'b1;
            fast_res_s = is_rem(op_s) ? a_i : ONES;
        end else if (is_div(op_s) && is_signed_a(op_s) && (a_i == SMIN) && (b_i == ONES)) begin
            fast_s     = 1'b1;
            fast_res_s = is_rem(op_s) ? ZERO : SMIN;
        end else begin
            fast_s     = 1'b0;
        end
`else
        if (is_div(op_s)) begin
            fast_s     = 1'b1;
            fast_ill_s = 1'b1;
        end else begin
            fast_s     = 1'b0;
        end
`endif
    end

    rv32i_muldiv_step #(.XLEN(XLEN)) u_step (
        .div_i (is_div(op_q)),
        .acc_i (acc_q),
        .lo_i  (lo_q),
        .opb_i (opb_q),
        .acc_o (acc_d),
        .lo_o  (lo_d)
    );

    // Sign correction and word selection on the final iteration's output
    always_comb begin
        prod_s = neg_q ? ({(2*XLEN){1'b0}} - {acc_d, lo_d}) : {acc_d, lo_d};
        if (is_div(op_q)) begin
            if (is_rem(op_q)) begin
                fin_s = rneg_q ? (ZERO - acc_d) : acc_d;
            end else begin
                fin_s = neg_q ? (ZERO - lo_d) : lo_d;
            end
        end else if (returns_high(op_q)) begin
            fin_s = prod_s[2*XLEN-1:XLEN];
        end else begin
            fin_s = prod_s[XLEN-1:0];
        end
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MDU_IDLE;
            op_q      <= MDU_MUL;
            cnt_q     <= {CW{1'b0}};
            acc_q     <= ZERO;
            lo_q      <= ZERO;
            opb_q     <= ZERO;
            pre_q     <= ZERO;
            result_q  <= ZERO;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            fast_q    <= 1'b0;
            ill_q     <= 1'b0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                MDU_IDLE: begin
                    if (start_i) begin
                        ready_q <= 1'b0;
                        op_q    <= op_s;
                        fast_q  <= fast_s;
                        ill_q   <= fast_ill_s;
                        pre_q   <= fast_res_s;
                        acc_q   <= ZERO;
                        lo_q    <= a_mag_s;
                        opb_q   <= b_mag_s;
                        neg_q   <= a_neg_s ^ b_neg_s;
                        rneg_q  <= a_neg_s;
                        cnt_q   <= CW'(XLEN - 1);
                        state_q <= fast_s ? MDU_DONE : MDU_CALC;
                    end
                end
                MDU_CALC: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    // The last iteration's result is registered directly so valid_o lands XLEN edges after acceptance
                    if (cnt_q == {CW{1'b0}}) begin
                        result_q <= fin_s;
                        valid_q  <= 1'b1;
                        state_q  <= MDU_DONE;
                    end else begin
                        cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                MDU_DONE: begin
                    if (fast_q) begin
                        result_q  <= pre_q;
                        valid_q   <= 1'b1;
                        illegal_q <= ill_q;
                    end
                    ready_q <= 1'b1;
                    state_q <= MDU_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= MDU_IDLE;
                end
            endcase
        end
    end

    assign ready_o   = ready_q;
    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_rv32i_muldiv.sv
// Self-checking bench for rv32i_muldiv: directed vector table, corner sequences, random ops vs. arithmetic model.
module tb_rv32i_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        ready_o, valid_o, illegal_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .result_o  (result_o),
        .illegal_o (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: RISC-V RV32M semantics via 64-bit arithmetic
    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sbu, r;
        logic [63:0] ua, ub, u;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        sbu = {32'h0, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        r   = 64'sd0;
        u   = 64'd0;
`ifndef RV32I_MDU_DIV_EN
        if (op >= 3'd4) return 32'h0;
`endif
        case (op)
            3'd0: begin r = sa * sb;  return r[31:0];  end
            3'd1: begin r = sa * sb;  return r[63:32]; end
            3'd2: begin r = sa * sbu; return r[63:32]; end
            3'd3: begin u = ua * ub;  return u[63:32]; end
            3'd4: begin if (b == 32'h0) return 32'hFFFF_FFFF; r = sa / sb; return r[31:0]; end
            3'd5: begin if (b == 32'h0) return 32'hFFFF_FFFF; u = ua / ub; return u[31:0]; end
            3'd6: begin if (b == 32'h0) return a; r = sa % sb; return r[31:0]; end
            default: begin if (b == 32'h0) return a; u = ua % ub; return u[31:0]; end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return 32;
`ifdef RV32I_MDU_DIV_EN
        if (b == 32'h0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 32;
`else
        return 1;
`endif
    endfunction

    function automatic logic model_ill(input logic [2:0] op);
`ifdef RV32I_MDU_DIV_EN
        return 1'b0;
`else
        return op >= 3'd4;
`endif
    endfunction

    // Issue one op, optionally pulse start_i at CALC cycle 'glitch', and collect result/latency
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int glitch,
                          output logic [31:0] res, output logic ill, output int lat);
        int w;
        lat = -1; res = 32'h0; ill = 1'b0; w = 0;
        while (!ready_o && w < 100) begin
            @(posedge clk); #1; w++;
        end
        check("ready_before_start", {31'h0, ready_o}, 32'h1);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
        for (int n = 1; n <= 100; n++) begin
            start_i = (n == glitch);
            @(posedge clk); #1;
            if (valid_o) begin
                lat = n; res = result_o; ill = illegal_o;
                break;
            end
        end
        start_i = 1'b0;
        if (lat > 0) begin
            @(posedge clk); #1;
            check("valid_single_pulse", {31'h0, valid_o}, 32'h0);
            check("result_held", result_o, res);
        end
    endtask

    task automatic apply(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int glitch, input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
        logic [31:0] res;
        logic        ill;
        int          lat;
        run_op(op, a, b, glitch, res, ill, lat);
        check({name, "_result"}, res, exp_res);
        check({name, "_illegal"}, {31'h0, ill}, {31'h0, exp_ill});
        check({name, "_latency"}, lat, exp_lat);
    endtask

    vec_t tbl[14];

    initial begin
        logic [31:0] er, ra, rb;
        logic        ei;
        logic [2:0]  rop;
        int          el, sel;

        tbl[0]  = '{"mul_7_m3",       3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32};
        tbl[1]  = '{"mulhu_ones",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
        tbl[2]  = '{"mulh_ones",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32};
        tbl[3]  = '{"mulhsu_m1_2",    3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32};
        tbl[4]  = '{"div_m7_2",       3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32};
        tbl[5]  = '{"rem_m7_2",       3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32};
        tbl[6]  = '{"divu_100_7",     3'd5, 32'd100,        32'd7,         32'd14,        32};
        tbl[7]  = '{"remu_100_7",     3'd7, 32'd100,        32'd7,         32'd2,         32};
        tbl[8]  = '{"divu_by_zero",   3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        tbl[9]  = '{"rem_by_zero",    3'd6, 32'd5,          32'd0,         32'd5,         1};
        tbl[10] = '{"div_overflow",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[11] = '{"rem_overflow",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        tbl[12] = '{"mulhu_min_min",  3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32};
        tbl[13] = '{"div_10_2",       3'd4, 32'd10,         32'd2,         32'd5,         32};

        rst_n = 1'b0; start_i = 1'b0; op_i = 3'd0; a_i = 32'h0; b_i = 32'h0;
        #12;
        check("reset_ready",   {31'h0, ready_o},   32'h1);
        check("reset_valid",   {31'h0, valid_o},   32'h0);
        check("reset_result",  result_o,           32'h0);
        check("reset_illegal", {31'h0, illegal_o}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            er = tbl[i].res; el = tbl[i].lat; ei = 1'b0;
`ifndef RV32I_MDU_DIV_EN
            if (tbl[i].op >= 3'd4) begin er = 32'h0; el = 1; ei = 1'b1; end
`endif
            apply(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, 0, er, ei, el);
        end

        // start_i pulsed while busy is dropped
        apply("mul_glitch_start", 3'd0, 32'd7, 32'hFFFF_FFFD, 5, 32'hFFFF_FFEB, 1'b0, 32);
        apply("remu_glitch_start", 3'd7, 32'd100, 32'd7, 9,
              model_res(3'd7, 32'd100, 32'd7), model_ill(3'd7), model_lat(3'd7, 32'd100, 32'd7));

        // asynchronous reset at iteration 10 discards the op
        op_i = 3'd1; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_ready",   {31'h0, ready_o},   32'h1);
        check("midreset_valid",   {31'h0, valid_o},   32'h0);
        check("midreset_result",  result_o,           32'h0);
        check("midreset_illegal", {31'h0, illegal_o}, 32'h0);
        #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postreset_valid", {31'h0, valid_o}, 32'h0);
        apply("post_reset_mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 1'b0, 32);

        for (int k = 0; k < 48; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'h0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) begin ra = 32'($urandom_range(0, 300)); rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); end
            apply($sformatf("rand%0d_op%0d", k, rop), rop, ra, rb, 0,
                  model_res(rop, ra, rb), model_ill(rop), model_lat(rop, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
